bp_be_sys_retire_gen: RTL and testbench
=======================================

# bp_be_sys_retire_gen

Fixed-latency retire generator for the backend system pipe. It tracks each dispatched instruction through two execute stages and accumulates per-stage exception bits. Exactly two cycles after dispatch it presents the retire stream (valid, queue-valid, data, exception, pc, instr) consumed by the system pipe's CSR/commit logic. It also squashes younger instructions when an excepting instruction retires, and keeps in-flight and instret counters.

## Interface
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- dpath_width_p, 66, retire data width
- exc_width_p, 16, exception bit-vector width (one-hot-or-more flags)
- instret_width_p, 64, instret counter width
- clk_i  in  1  clock; one clock domain
- reset_i  in  1  asynchronous, active-high reset
- dispatch_v_i  in  1  instruction dispatched this cycle
- dispatch_queue_v_i  in  1  instruction consumes a fetch-queue entry
- dispatch_pc_i  in  vaddr_width_p  dispatch PC
- dispatch_instr_i  in  instr_width_p  dispatch instruction
- dispatch_exc_i  in  exc_width_p  exceptions known at dispatch
- ex1_exc_i  in  exc_width_p  exceptions raised by the stage-1 instruction
- ex2_exc_i  in  exc_width_p  exceptions raised by the stage-2 instruction
- ex2_data_i  in  dpath_width_p  result of the stage-2 instruction
- flush_i  in  1  external flush; kill everything not yet retired
- retire_v_o  out  1  instruction retires this cycle
- retire_queue_v_o  out  1  retiring instruction frees a queue entry
- retire_data_o  out  dpath_width_p  retire data
- retire_exception_o  out  exc_width_p  accumulated exceptions
- retire_pc_o  out  vaddr_width_p  retiring PC
- retire_instr_o  out  instr_width_p  retiring instruction
- inflight_o  out  2  valid instructions in stages 1 and 2 (0..2)
- empty_o  out  1  inflight_o == 0
- instret_o  out  instret_width_p  count of exception-free retirements

## Operation
- Stage registers:
  - s1 holds {v, queue_v, pc, instr, exc}.
  - s2 holds the same fields.
  - No stall: the pipe advances every cycle.
- Cycle edge, normal operation:
  - s1 ← dispatch inputs. s1.v = dispatch_v_i.
  - s2 ← s1. s2.exc = s1.exc | ex1_exc_i.
- kill = flush_i | (retire_v_o & |retire_exception_o).
- On an edge with kill = 1:
  - s1.v and s2.v ← 0.
  - The same-cycle dispatch is dropped.
  - The retiring instruction itself still retires this cycle.
- Retire outputs are combinational from s2 and are all-zero when s2.v = 0:
  - retire_v_o = s2.v.
  - retire_exception_o = s2.exc | ex2_exc_i.
  - retire_data_o = ex2_data_i.
  - retire_pc_o = s2.pc.
  - retire_instr_o = s2.instr.
  - retire_queue_v_o = s2.v & s2.queue_v & ~|retire_exception_o.
- flush_i does not suppress the current cycle's retire. It affects only s1/s2 at the next edge.
- Payload fields of invalid stages are don't-care internally. They must never reach the outputs ungated.
- instret_o increments by 1 on each edge with retire_v_o & ~|retire_exception_o. It wraps modulo 2^instret_width_p, with no saturation.
- inflight_o = s1.v + s2.v. empty_o = ~s1.v & ~s2.v.

## Timing
- Latency: dispatch in cycle N → retire_v_o in cycle N+2, with no bubbles. Throughput is 1 per cycle.
- Reset (asynchronous assert) clears s1.v, s2.v and instret. Consequences during reset:
  - retire_v_o, retire_queue_v_o, retire_data_o, retire_exception_o, retire_pc_o, retire_instr_o = 0.
  - inflight_o = 0, empty_o = 1, instret_o = 0.
- Reset mid-stream: in-flight instructions vanish. No retire is produced for them after reset deasserts.
- Simultaneous events:
  - flush_i together with an excepting retire: a single kill. The retire is reported once.
  - Dispatch together with kill: the dispatch is lost. The issuing logic must re-dispatch.
- Back-to-back excepting instructions: only the older one retires. The younger one is squashed at the same edge.
- An ex2_exc_i arriving while s2.v = 0 is ignored.

## Test plan
- Dispatch pc=0x100, 0x104, 0x108 in cycles 0-2, no exceptions, queue_v=1 → retire_v_o=1 in cycles 2-4 with pc 0x100/0x104/0x108 and retire_queue_v_o=1 each; instret_o=3 in cycle 5; empty_o=1 in cycle 5.
- Dispatch A (cycle 0) and B (cycle 1); ex1_exc_i=0x0004 in cycle 1 → A retires in cycle 2 with exception 0x0004 and retire_queue_v_o=0. B never retires. inflight_o=0 in cycle 3. instret_o unchanged.
- Dispatch A (cycle 0) with dispatch_exc_i=0x0001; ex2_exc_i=0x0010 in cycle 2 → retire_exception_o=0x0011 in cycle 2.
- Dispatch every cycle; flush_i=1 in cycle 3 → the instruction dispatched in cycle 1 still retires in cycle 3. The instructions dispatched in cycles 2 and 3 never retire. The cycle-4 dispatch retires in cycle 6.
- Assert reset_i asynchronously mid-cycle with two instructions in flight → all outputs are 0 immediately and empty_o=1. After release, no retire occurs until 2 cycles after a new dispatch.
- instret_width_p=4, 17 clean retirements → instret_o=1 (wrapped).

Source files
------------

// File: rtl/bp_be_sys_retire_gen_if.sv
// Dispatch/execute/retire bundle between the backend system pipe and the retire generator.
interface bp_be_sys_retire_gen_if #(
  parameter int vaddr_width_p   = 39,
  parameter int instr_width_p   = 32,
  parameter int dpath_width_p   = 66,
  parameter int exc_width_p     = 16,
  parameter int instret_width_p = 64
) ();
  logic                       dispatch_v_i;
  logic                       dispatch_queue_v_i;
  logic [vaddr_width_p-1:0]   dispatch_pc_i;
  logic [instr_width_p-1:0]   dispatch_instr_i;
  logic [exc_width_p-1:0]     dispatch_exc_i;
  logic [exc_width_p-1:0]     ex1_exc_i;
  logic [exc_width_p-1:0]     ex2_exc_i;
  logic [dpath_width_p-1:0]   ex2_data_i;
  logic                       flush_i;

  logic                       retire_v_o;
  logic                       retire_queue_v_o;
  logic [dpath_width_p-1:0]   retire_data_o;
  logic [exc_width_p-1:0]     retire_exception_o;
  logic [vaddr_width_p-1:0]   retire_pc_o;
  logic [instr_width_p-1:0]   retire_instr_o;
  logic [1:0]                 inflight_o;
  logic                       empty_o;
  logic [instret_width_p-1:0] instret_o;

  modport master (
    output dispatch_v_i, dispatch_queue_v_i, dispatch_pc_i, dispatch_instr_i, dispatch_exc_i,
           ex1_exc_i, ex2_exc_i, ex2_data_i, flush_i,
    input  retire_v_o, retire_queue_v_o, retire_data_o, retire_exception_o, retire_pc_o,
           retire_instr_o, inflight_o, empty_o, instret_o
  );

  modport slave (
    input  dispatch_v_i, dispatch_queue_v_i, dispatch_pc_i, dispatch_instr_i, dispatch_exc_i,
           ex1_exc_i, ex2_exc_i, ex2_data_i, flush_i,
    output retire_v_o, retire_queue_v_o, retire_data_o, retire_exception_o, retire_pc_o,
           retire_instr_o, inflight_o, empty_o, instret_o
  );
endinterface

// File: rtl/bp_be_sys_retire_gen.sv
// Fixed two-cycle retire generator: tracks dispatched instructions through ex1/ex2,
// accumulates exceptions, squashes younger work on an excepting retire or flush,
// and keeps in-flight / instret counters.
module bp_be_sys_retire_gen #(
  parameter int vaddr_width_p   = 39,
  parameter int instr_width_p   = 32,
  parameter int dpath_width_p   = 66,
  parameter int exc_width_p     = 16,
  parameter int instret_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_be_sys_retire_gen_if.slave   io
);

  logic                       s1_v_q, s1_v_d, s1_qv_q, s1_qv_d;
  logic [vaddr_width_p-1:0]   s1_pc_q, s1_pc_d;
  logic [instr_width_p-1:0]   s1_instr_q, s1_instr_d;
  logic [exc_width_p-1:0]     s1_exc_q, s1_exc_d;

  logic                       s2_v_q, s2_v_d, s2_qv_q, s2_qv_d;
  logic [vaddr_width_p-1:0]   s2_pc_q, s2_pc_d;
  logic [instr_width_p-1:0]   s2_instr_q, s2_instr_d;
  logic [exc_width_p-1:0]     s2_exc_q, s2_exc_d;

  logic [instret_width_p-1:0] instret_q, instret_d;

  logic                       kill;
  logic [exc_width_p-1:0]     retire_exc;
  logic                       retire_clean;

  // Retire view of stage 2; all payload gated by s2 valid so stale fields never leak.
  always_comb begin
    retire_exc   = s2_v_q ? (s2_exc_q | io.ex2_exc_i) : '0;
    retire_clean = s2_v_q & ~|retire_exc;
    kill         = io.flush_i | (s2_v_q & |retire_exc);
  end

  // Next-state: advance every cycle; a kill empties both stages and drops the dispatch.
  always_comb begin
    s1_v_d     = io.dispatch_v_i & ~kill;
    s1_qv_d    = io.dispatch_queue_v_i;
    s1_pc_d    = io.dispatch_pc_i;
    s1_instr_d = io.dispatch_instr_i;
    s1_exc_d   = io.dispatch_exc_i;

    s2_v_d     = s1_v_q & ~kill;
    s2_qv_d    = s1_qv_q;
    s2_pc_d    = s1_pc_q;
    s2_instr_d = s1_instr_q;
    s2_exc_d   = s1_exc_q | io.ex1_exc_i;

    instret_d  = retire_clean ? instret_q + instret_width_p'(1) : instret_q;
  end

  // Pipeline and counter registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q     <= 1'b0;
      s1_qv_q    <= 1'b0;
      s1_pc_q    <= '0;
      s1_instr_q <= '0;
      s1_exc_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_qv_q    <= 1'b0;
      s2_pc_q    <= '0;
      s2_instr_q <= '0;
      s2_exc_q   <= '0;
      instret_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_qv_q    <= s1_qv_d;
      s1_pc_q    <= s1_pc_d;
      s1_instr_q <= s1_instr_d;
      s1_exc_q   <= s1_exc_d;
      s2_v_q     <= s2_v_d;
      s2_qv_q    <= s2_qv_d;
      s2_pc_q    <= s2_pc_d;
      s2_instr_q <= s2_instr_d;
      s2_exc_q   <= s2_exc_d;
      instret_q  <= instret_d;
    end
  end

  assign io.retire_v_o         = s2_v_q;
  assign io.retire_queue_v_o   = retire_clean & s2_qv_q;
  assign io.retire_exception_o = retire_exc;
  assign io.retire_data_o      = s2_v_q ? io.ex2_data_i : '0;
  assign io.retire_pc_o        = s2_v_q ? s2_pc_q : '0;
  assign io.retire_instr_o     = s2_v_q ? s2_instr_q : '0;
  assign io.inflight_o         = {1'b0, s1_v_q} + {1'b0, s2_v_q};
  assign io.empty_o            = ~s1_v_q & ~s2_v_q;
  assign io.instret_o          = instret_q;

endmodule

// File: tb/tb_bp_be_sys_retire_gen.sv
// Scoreboard bench for bp_be_sys_retire_gen: driver pushes expected retires from a
// cycle-stamped reference model, a negedge monitor pops and compares.
module tb_bp_be_sys_retire_gen;
  localparam int VW = 39, IW = 32, DW = 66, EW = 16, RW = 4;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bp_be_sys_retire_gen_if #(.vaddr_width_p(VW), .instr_width_p(IW), .dpath_width_p(DW),
                            .exc_width_p(EW), .instret_width_p(RW)) bus ();

  bp_be_sys_retire_gen #(.vaddr_width_p(VW), .instr_width_p(IW), .dpath_width_p(DW),
                         .exc_width_p(EW), .instret_width_p(RW)) dut (
    .clk_i(clk), .reset_i(reset_i), .io(bus.slave));

  typedef struct {
    logic [VW-1:0] pc; logic [IW-1:0] instr; logic [EW-1:0] exc; logic qv; int d;
  } ent_t;
  typedef struct {
    int c; logic [VW-1:0] pc; logic [IW-1:0] instr; logic [EW-1:0] exc;
    logic [DW-1:0] data; logic qv;
  } exp_t;

  ent_t pend[$];
  exp_t sb[$];
  int   cyc = 0;
  int   instret_m = 0;
  int   exp_inflight = 0;
  int   exp_instret = 0;
  bit   active = 1'b0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [EW-1:0] rnd_exc();
    logic [EW-1:0] e;
    e = '0;
    if ($urandom_range(0, 9) == 0) e = (EW'(1) << $urandom_range(0, EW-1)) | EW'($urandom & $urandom);
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] rnd_pc();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[VW-1:0];
  endfunction

  // One clock cycle: drive inputs, predict this cycle's retire, then apply the edge to the model.
  task automatic cycle(input logic dv, input logic qv, input logic [VW-1:0] pc,
                       input logic [IW-1:0] ins, input logic [EW-1:0] dexc,
                       input logic [EW-1:0] ex1, input logic [EW-1:0] ex2,
                       input logic [DW-1:0] data, input logic fl);
    bit   rv, kill;
    exp_t x;
    ent_t n;
    bus.dispatch_v_i = dv; bus.dispatch_queue_v_i = qv; bus.dispatch_pc_i = pc;
    bus.dispatch_instr_i = ins; bus.dispatch_exc_i = dexc; bus.ex1_exc_i = ex1;
    bus.ex2_exc_i = ex2; bus.ex2_data_i = data; bus.flush_i = fl;
    exp_inflight = pend.size();
    exp_instret  = instret_m;
    rv = (pend.size() > 0) && (pend[0].d == cyc - 2);
    x.exc = '0;
    if (rv) begin
      x.c = cyc; x.pc = pend[0].pc; x.instr = pend[0].instr;
      x.exc = pend[0].exc | ex2; x.data = data;
      x.qv = pend[0].qv && (x.exc == '0);
      sb.push_back(x);
    end
    kill = fl || (rv && x.exc != '0);
    active = 1'b1;
    @(posedge clk);
    if (rv) begin
      void'(pend.pop_front());
      if (x.exc == '0) instret_m = (instret_m + 1) % (1 << RW);
    end
    if (kill) pend.delete();
    else begin
      if (pend.size() > 0) pend[0].exc = pend[0].exc | ex1;
      if (dv) begin
        n.pc = pc; n.instr = ins; n.exc = dexc; n.qv = qv; n.d = cyc;
        pend.push_back(n);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, '0, '0, '0, rnd_data(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_retire_v"}, bus.retire_v_o, 0);
    chk({tag, "_retire_qv"}, bus.retire_queue_v_o, 0);
    chk({tag, "_retire_data"}, bus.retire_data_o, 0);
    chk({tag, "_retire_exc"}, bus.retire_exception_o, 0);
    chk({tag, "_retire_pc"}, bus.retire_pc_o, 0);
    chk({tag, "_retire_instr"}, bus.retire_instr_o, 0);
    chk({tag, "_inflight"}, bus.inflight_o, 0);
    chk({tag, "_empty"}, bus.empty_o, 1);
    chk({tag, "_instret"}, bus.instret_o, 0);
  endtask

  // Asynchronous reset in the middle of a cycle while instructions are in flight.
  task automatic mid_reset();
    bus.dispatch_v_i = 1'b1; bus.dispatch_queue_v_i = 1'b1; bus.flush_i = 1'b0;
    bus.ex1_exc_i = '0; bus.ex2_exc_i = '0; bus.ex2_data_i = rnd_data();
    #1 reset_i = 1'b1;
    #1 chk_reset_outputs("midreset");
    pend.delete(); sb.delete(); instret_m = 0;
    @(posedge clk);
    cyc++;
    #1 reset_i = 1'b0;
  endtask

  // Monitor: compare status every cycle; pop the scoreboard whenever the DUT retires.
  always @(negedge clk) begin
    if (active && !reset_i) begin
      chk("inflight", bus.inflight_o, exp_inflight);
      chk("empty", bus.empty_o, exp_inflight == 0);
      chk("instret", bus.instret_o, exp_instret);
      if (bus.retire_v_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", bus.retire_v_o, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("retire_cycle", cyc, x.c);
          chk("retire_pc", bus.retire_pc_o, x.pc);
          chk("retire_instr", bus.retire_instr_o, x.instr);
          chk("retire_exc", bus.retire_exception_o, x.exc);
          chk("retire_data", bus.retire_data_o, x.data);
          chk("retire_qv", bus.retire_queue_v_o, x.qv);
        end
      end else begin
        chk("idle_qv", bus.retire_queue_v_o, 0);
        chk("idle_data", bus.retire_data_o, 0);
        chk("idle_exc", bus.retire_exception_o, 0);
        chk("idle_pc", bus.retire_pc_o, 0);
        chk("idle_instr", bus.retire_instr_o, 0);
        if (sb.size() > 0 && sb[0].c <= cyc) begin
          chk("missing_retire", bus.retire_v_o, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bus.dispatch_v_i = 0; bus.dispatch_queue_v_i = 0; bus.dispatch_pc_i = '0;
    bus.dispatch_instr_i = '0; bus.dispatch_exc_i = '0; bus.ex1_exc_i = '0;
    bus.ex2_exc_i = '0; bus.ex2_data_i = 66'h3_dead_beef_cafe_f00d; bus.flush_i = 0;
    #12 chk_reset_outputs("reset");
    @(posedge clk); #1 reset_i = 1'b0;

    // Three clean back-to-back instructions.
    cycle(1, 1, 39'h100, 32'h13, '0, '0, '0, rnd_data(), 0);
    cycle(1, 1, 39'h104, 32'h93, '0, '0, '0, rnd_data(), 0);
    cycle(1, 1, 39'h108, 32'h113, '0, '0, '0, rnd_data(), 0);
    idle(3);
    chk("plan1_instret", bus.instret_o, 3);

    // ex1 exception on A squashes B.
    cycle(1, 1, 39'h200, 32'h1, '0, '0, '0, rnd_data(), 0);
    cycle(1, 1, 39'h204, 32'h2, '0, 16'h0004, '0, rnd_data(), 0);
    idle(3);

    // Dispatch exception merged with ex2 exception.
    cycle(1, 1, 39'h300, 32'h3, 16'h0001, '0, '0, rnd_data(), 0);
    cycle(0, 0, '0, '0, '0, '0, '0, rnd_data(), 0);
    cycle(0, 0, '0, '0, '0, '0, 16'h0010, rnd_data(), 0);
    idle(2);

    // Dispatch every cycle, flush in relative cycle 3.
    for (int k = 0; k < 8; k++)
      cycle(1, 1, 39'h400 + 39'(4 * k), 32'(k), '0, '0, '0, rnd_data(), k == 3);
    idle(3);

    // Reset with two instructions in flight, then a fresh dispatch.
    cycle(1, 1, 39'h500, 32'h5, '0, '0, '0, rnd_data(), 0);
    cycle(1, 1, 39'h504, 32'h6, '0, '0, '0, rnd_data(), 0);
    mid_reset();
    idle(2);
    cycle(1, 0, 39'h600, 32'h7, '0, '0, '0, rnd_data(), 0);
    idle(3);

    // Randomised traffic; instret wraps many times at this counter width.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(1, 1, rnd_pc(), $urandom, '0, '0, '0, rnd_data(), 0);
        cycle(1, 1, rnd_pc(), $urandom, '0, '0, '0, rnd_data(), 0);
        mid_reset();
      end
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, rnd_pc(), $urandom,
            rnd_exc(), rnd_exc(), rnd_exc(), rnd_data(), $urandom_range(0, 11) == 0);
    end
    idle(4);
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
